// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage request / hazard response bundle for scoreboard_hazard_unit.
// HAZARD_STATS_EN adds the stall/flush counter outputs.
interface scoreboard_hazard_unit_if #(
  parameter int AW = 5,
  parameter int FW = 2
);
  logic          id_valid_i;
  logic [AW-1:0] id_rs_i;
  logic [AW-1:0] id_rt_i;
  logic          id_rs_use_i;
  logic          id_rt_use_i;
  logic          id_wr_i;
  logic [AW-1:0] id_rd_i;
  logic          id_load_i;
  logic          flush_i;
  logic          stall_o;
  logic          issue_o;
  logic [FW-1:0] fwd_rs_o;
  logic [FW-1:0] fwd_rt_o;
  logic          busy_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cnt_o;
  logic [31:0]   flush_cnt_o;

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           id_wr_i, id_rd_i, id_load_i, flush_i,
    output stall_o, issue_o, fwd_rs_o, fwd_rt_o, busy_o, stall_cnt_o, flush_cnt_o
  );
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           id_wr_i, id_rd_i, id_load_i, flush_i,
    input  stall_o, issue_o, fwd_rs_o, fwd_rt_o, busy_o, stall_cnt_o, flush_cnt_o
  );
`else
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           id_wr_i, id_rd_i, id_load_i, flush_i,
    output stall_o, issue_o, fwd_rs_o, fwd_rt_o, busy_o
  );
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           id_wr_i, id_rd_i, id_load_i, flush_i,
    input  stall_o, issue_o, fwd_rs_o, fwd_rt_o, busy_o
  );
`endif
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register writer-age scoreboard driving load-use stall, forward taps and issue.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module scoreboard_hazard_entry #(
  parameter int DEPTH = 3,
  parameter int FW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          set_ld,
  output logic [FW-1:0] age,
  output logic          ld
);
  // A new writer restarts the entry; otherwise the age walks toward writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
      ld  <= 1'b0;
    end else if (set) begin
      age <= FW'(1);
      ld  <= set_ld;
    end else if (age == FW'(DEPTH-1)) begin
      age <= '0;
      ld  <= 1'b0;
    end else if (age != '0) begin
      age <= age + FW'(1);
    end
  end
endmodule

module scoreboard_hazard_unit #(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int FW       = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  scoreboard_hazard_unit_if.slave sb
);
  logic [NREG-1:0][FW-1:0] age;
  logic [NREG-1:0]         ld;
  logic [NREG-1:0]         set;

  logic          live, stall, issue;
  logic          use_rs, use_rt, haz_rs, haz_rt;
  logic [FW-1:0] age_rs, age_rt;

  assign age[0] = '0;
  assign ld[0]  = 1'b0;
  assign set[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_ent
      assign set[r] = issue & sb.id_wr_i & (sb.id_rd_i == AW'(r));
      scoreboard_hazard_entry #(.DEPTH(DEPTH), .FW(FW)) u_ent (
        .clk    (clk_i),
        .rst    (rst_i),
        .set    (set[r]),
        .set_ld (sb.id_load_i),
        .age    (age[r]),
        .ld     (ld[r])
      );
    end
  endgenerate

  // Lookups use pre-update state, so rs == rd of the same instruction sees the old writer.
  assign age_rs = age[sb.id_rs_i];
  assign age_rt = age[sb.id_rt_i];
  assign use_rs = sb.id_rs_use_i & (sb.id_rs_i != '0);
  assign use_rt = sb.id_rt_use_i & (sb.id_rt_i != '0);
  assign haz_rs = use_rs & (age_rs != '0) & ld[sb.id_rs_i] & (age_rs < FW'(LOAD_LAT));
  assign haz_rt = use_rt & (age_rt != '0) & ld[sb.id_rt_i] & (age_rt < FW'(LOAD_LAT));

  assign live  = sb.id_valid_i & ~sb.flush_i;
  assign stall = live & (haz_rs | haz_rt);
  assign issue = live & ~stall;

  assign sb.stall_o  = stall;
  assign sb.issue_o  = issue;
  assign sb.fwd_rs_o = use_rs ? age_rs : '0;
  assign sb.fwd_rt_o = use_rt ? age_rt : '0;
  assign sb.busy_o   = |age;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (sb.id_valid_i && sb.flush_i && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign sb.stall_cnt_o = stall_cnt;
  assign sb.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Drives three scoreboard configurations with shared directed + random ID traffic and
// compares against an issue-history model (age = cycles since the youngest issue).
module tb_scoreboard_hazard_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, v, fl, ru, tu, wr, ldi;
  logic [4:0] rs, rt, rd;

  scoreboard_hazard_unit_if #(.AW(5), .FW(2)) if_a ();
  scoreboard_hazard_unit_if #(.AW(5), .FW(2)) if_b ();
  scoreboard_hazard_unit_if #(.AW(5), .FW(3)) if_c ();

`define TB_DRIVE(IFX) \
  assign IFX.id_valid_i = v;   assign IFX.id_rs_i = rs;     assign IFX.id_rt_i = rt; \
  assign IFX.id_rs_use_i = ru; assign IFX.id_rt_use_i = tu; assign IFX.id_wr_i = wr; \
  assign IFX.id_rd_i = rd;     assign IFX.id_load_i = ldi;  assign IFX.flush_i = fl;
  `TB_DRIVE(if_a)
  `TB_DRIVE(if_b)
  `TB_DRIVE(if_c)

  scoreboard_hazard_unit #(.DEPTH(3), .LOAD_LAT(2)) dut_a (.clk_i(clk), .rst_i(rst), .sb(if_a));
  scoreboard_hazard_unit #(.DEPTH(3), .LOAD_LAT(1)) dut_b (.clk_i(clk), .rst_i(rst), .sb(if_b));
  scoreboard_hazard_unit #(.DEPTH(5), .LOAD_LAT(3)) dut_c (.clk_i(clk), .rst_i(rst), .sb(if_c));

  logic       o_st[3], o_is[3], o_bs[3];
  logic [2:0] o_frs[3], o_frt[3];
  assign o_st[0] = if_a.stall_o; assign o_is[0] = if_a.issue_o; assign o_bs[0] = if_a.busy_o;
  assign o_st[1] = if_b.stall_o; assign o_is[1] = if_b.issue_o; assign o_bs[1] = if_b.busy_o;
  assign o_st[2] = if_c.stall_o; assign o_is[2] = if_c.issue_o; assign o_bs[2] = if_c.busy_o;
  assign o_frs[0] = {1'b0, if_a.fwd_rs_o}; assign o_frt[0] = {1'b0, if_a.fwd_rt_o};
  assign o_frs[1] = {1'b0, if_b.fwd_rs_o}; assign o_frt[1] = {1'b0, if_b.fwd_rt_o};
  assign o_frs[2] = if_c.fwd_rs_o;         assign o_frt[2] = if_c.fwd_rt_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] o_sc[3], o_fc[3];
  assign o_sc[0] = if_a.stall_cnt_o; assign o_fc[0] = if_a.flush_cnt_o;
  assign o_sc[1] = if_b.stall_cnt_o; assign o_fc[1] = if_b.flush_cnt_o;
  assign o_sc[2] = if_c.stall_cnt_o; assign o_fc[2] = if_c.flush_cnt_o;
  int m_sc[3], m_fc[3];
`endif

  // Model: cycle number in which each register's youngest writer issued.
  int  dep[3] = '{3, 3, 5};
  int  lat[3] = '{2, 1, 3};
  int  wcyc[3][32];
  bit  wld[3][32];
  int  cyc = 0;
  bit  armed = 1'b0;
  int  n_chk = 0, n_err = 0;
  logic       s_st[3], s_is[3], s_bs[3];
  logic [2:0] s_frs[3], s_frt[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mage(int k, int r);
    int d;
    if (r == 0) return 0;
    d = cyc - wcyc[k][r];
    return (d >= 1 && d <= dep[k] - 1) ? d : 0;
  endfunction

  function automatic bit mhaz(int k, int s, bit u);
    int a;
    a = mage(k, s);
    return u && s != 0 && a != 0 && wld[k][s] && a < lat[k];
  endfunction

  task automatic step(input logic r_, v_, fl_, input int rs_, input logic ru_,
                      input int rt_, input logic tu_, input logic wr_, input int rd_,
                      input logic ld_);
    bit e_st[3], e_is[3], e_bs[3];
    int e_frs, e_frt;
    @(negedge clk);
    rst = r_; v = v_; fl = fl_; rs = 5'(rs_); ru = ru_; rt = 5'(rt_); tu = tu_;
    wr = wr_; rd = 5'(rd_); ldi = ld_;
    #1;
    for (int k = 0; k < 3; k++) begin
      e_st[k] = v_ && !fl_ && (mhaz(k, rs_, ru_) || mhaz(k, rt_, tu_));
      e_is[k] = v_ && !fl_ && !e_st[k];
      e_frs   = (ru_ && rs_ != 0) ? mage(k, rs_) : 0;
      e_frt   = (tu_ && rt_ != 0) ? mage(k, rt_) : 0;
      e_bs[k] = 1'b0;
      for (int r = 1; r < 32; r++) if (mage(k, r) != 0) e_bs[k] = 1'b1;
      s_st[k] = o_st[k]; s_is[k] = o_is[k]; s_bs[k] = o_bs[k];
      s_frs[k] = o_frs[k]; s_frt[k] = o_frt[k];
      if (armed) begin
        chk($sformatf("stall%0d", k), 32'(o_st[k]), 32'(e_st[k]));
        chk($sformatf("issue%0d", k), 32'(o_is[k]), 32'(e_is[k]));
        chk($sformatf("fwd_rs%0d", k), 32'(o_frs[k]), 32'(e_frs));
        chk($sformatf("fwd_rt%0d", k), 32'(o_frt[k]), 32'(e_frt));
        chk($sformatf("busy%0d", k), 32'(o_bs[k]), 32'(e_bs[k]));
`ifdef HAZARD_STATS_EN
        chk($sformatf("stall_cnt%0d", k), o_sc[k], 32'(m_sc[k]));
        chk($sformatf("flush_cnt%0d", k), o_fc[k], 32'(m_fc[k]));
`endif
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r_) begin
        for (int r = 0; r < 32; r++) begin wcyc[k][r] = -100; wld[k][r] = 1'b0; end
      end else if (e_is[k] && wr_ && rd_ != 0) begin
        wcyc[k][rd_] = cyc;
        wld[k][rd_]  = ld_;
      end
`ifdef HAZARD_STATS_EN
      if (r_) begin m_sc[k] = 0; m_fc[k] = 0; end
      else begin
        if (e_st[k]) m_sc[k]++;
        if (v_ && fl_) m_fc[k]++;
      end
`endif
    end
    cyc++;
    armed = 1'b1;
  endtask

  // Shorthands: idle bubble, plain read, register write.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd_rs(input int s);  step(0, 1, 0, s, 1, 0, 0, 0, 0, 0); endtask
  task automatic rd_rt(input int s);  step(0, 1, 0, 0, 0, s, 1, 0, 0, 0); endtask
  task automatic wri(input int d, input logic l); step(0, 1, 0, 0, 0, 0, 0, 1, d, l); endtask

  initial begin
    // Reset held 2 cycles with a valid read of r5.
    step(1, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    chk("rst_stall", 32'(s_st[0]), 32'd0);
    chk("rst_fwd", 32'(s_frs[0]), 32'd0);
    chk("rst_busy", 32'(s_bs[0]), 32'd0);
    step(0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    chk("rst_rel_issue", 32'(s_is[0]), 32'd1);
    idle(5);

    // ALU back-to-back forwarding.
    wri(3, 0);
    rd_rs(3); chk("alu_fwd1", 32'(s_frs[0]), 32'd1); chk("alu_nostall", 32'(s_st[0]), 32'd0);
    rd_rt(3); chk("alu_fwd2", 32'(s_frt[0]), 32'd2);
    rd_rs(3); chk("alu_fwd0", 32'(s_frs[0]), 32'd0); chk("alu_idle", 32'(s_bs[0]), 32'd0);
    idle(5);

    // Load-use: one stall at LOAD_LAT 2, none at LOAD_LAT 1.
    wri(4, 1);
    rd_rt(4);
    chk("lu_stall", 32'(s_st[0]), 32'd1); chk("lu_noissue", 32'(s_is[0]), 32'd0);
    chk("lu1_nostall", 32'(s_st[1]), 32'd0); chk("lu1_fwd", 32'(s_frt[1]), 32'd1);
    rd_rt(4);
    chk("lu_fwd2", 32'(s_frt[0]), 32'd2); chk("lu_issue", 32'(s_is[0]), 32'd1);
    idle(5);

    // Youngest writer overrides an in-flight load.
    wri(7, 1); wri(7, 0);
    rd_rs(7); chk("ow_nostall", 32'(s_st[0]), 32'd0); chk("ow_fwd", 32'(s_frs[0]), 32'd1);
    idle(5);

    // Flush beats stall; the flushed r9 write is dropped.
    wri(2, 1);
    step(0, 1, 1, 2, 1, 0, 0, 1, 9, 0);
    chk("fl_stall", 32'(s_st[0]), 32'd0); chk("fl_issue", 32'(s_is[0]), 32'd0);
    rd_rs(9); chk("fl_r9", 32'(s_frs[0]), 32'd0);
    idle(5);

    // r0 writes never occupy the scoreboard; DEPTH 5 / LOAD_LAT 3 stalls twice.
    wri(0, 1);
    idle(1); chk("r0_busy", 32'(s_bs[0]), 32'd0);
    wri(1, 1);
    rd_rs(1); chk("d5_st1", 32'(s_st[2]), 32'd1);
    rd_rs(1); chk("d5_st2", 32'(s_st[2]), 32'd1);
    rd_rs(1); chk("d5_go", 32'(s_st[2]), 32'd0); chk("d5_fwd3", 32'(s_frs[2]), 32'd3);
    idle(1);
    idle(1); chk("d5_drain", 32'(s_bs[2]), 32'd0);

    // Random traffic on a small register window to force collisions.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 10,
           $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
           1'($urandom), $urandom_range(0, 7), $urandom_range(0, 99) < 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
